vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen_if.sv | 18 +
 rtl/vga_pattern_gen.sv | 75 +++++++
 tb/tb_vga_pattern_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: timing inputs into the pattern stage and its aligned sync/colour outputs
interface vga_pattern_gen_if;
  logic hsync_i, vsync_i, display_on_i;
  logic [9:0] hpos_i;
  logic [8:0] vpos_i;
  logic [1:0] pattern_sel_i;
  logic hsync_o, vsync_o;
  logic [3:0] red_o, green_o, blue_o;
  logic [7:0] frame_cnt_o;
  modport master (
    output hsync_i, vsync_i, display_on_i, hpos_i, vpos_i, pattern_sel_i,
    input  hsync_o, vsync_o, red_o, green_o, blue_o, frame_cnt_o
  );
  modport slave (
    input  hsync_i, vsync_i, display_on_i, hpos_i, vpos_i, pattern_sel_i,
    output hsync_o, vsync_o, red_o, green_o, blue_o, frame_cnt_o
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: per-pixel test pattern colour with sync delayed through the same 2-stage pipeline
module vga_pattern_gen (
  input logic clk_i,
  input logic rst_i,
  vga_pattern_gen_if.slave bus
);
  localparam logic [10:0] X_MAX = 11'd608;
  localparam logic [10:0] Y_MAX = 11'd448;
  logic vs_q, hs_q;
  logic [3:0] r_q, g_q, b_q;
  logic [1:0] pat;
  logic [9:0] box_x;
  logic [8:0] box_y;
  logic dir_x, dir_y;
  logic frame_start, chk, in_box, ndx, ndy;
  logic [2:0] bar;
  logic [3:0] r_n, g_n, b_n;
  logic [10:0] hx, vy, bx, by, nx, ny;
  always_comb begin
    frame_start = bus.vsync_i & ~vs_q;
    hx = {1'b0, bus.hpos_i};
    vy = {2'b0, bus.vpos_i};
    bx = {1'b0, box_x};
    by = {2'b0, box_y};
    bar = 3'(bus.hpos_i / 10'd80);
    chk = bus.hpos_i[5] ^ bus.vpos_i[5];
    in_box = hx >= bx && hx < bx + 11'd32 && vy >= by && vy < by + 11'd32;
    // bar order white..black makes each component a single inverted bit of the bar index
    r_n = pat == 2'd0 ? {4{~bar[1]}} : pat == 2'd1 ? {4{chk}} : pat == 2'd2 ? bus.hpos_i[6:3] : {4{in_box}};
    g_n = pat == 2'd0 ? {4{~bar[2]}} : pat == 2'd1 ? {4{chk}} : pat == 2'd2 ? bus.vpos_i[6:3] : {4{in_box}};
    b_n = pat == 2'd0 ? {4{~bar[0]}} : pat == 2'd1 ? {4{chk}} : pat == 2'd2 ? bus.frame_cnt_o[7:4] : 4'hF;
    nx = dir_x ? (bx < 11'd2 ? 11'd0 : bx - 11'd2) : (bx + 11'd2 > X_MAX ? X_MAX : bx + 11'd2);
    ndx = dir_x ? bx >= 11'd2 : bx + 11'd2 > X_MAX;
    ny = dir_y ? (by < 11'd2 ? 11'd0 : by - 11'd2) : (by + 11'd2 > Y_MAX ? Y_MAX : by + 11'd2);
    ndy = dir_y ? by >= 11'd2 : by + 11'd2 > Y_MAX;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      bus.hsync_o <= 1'b0;
      bus.vsync_o <= 1'b0;
      bus.red_o <= '0;
      bus.green_o <= '0;
      bus.blue_o <= '0;
      bus.frame_cnt_o <= '0;
      pat <= '0;
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
    end else begin
      vs_q <= bus.vsync_i;
      hs_q <= bus.hsync_i;
      r_q <= bus.display_on_i ? r_n : 4'h0;
      g_q <= bus.display_on_i ? g_n : 4'h0;
      b_q <= bus.display_on_i ? b_n : 4'h0;
      bus.hsync_o <= hs_q;
      bus.vsync_o <= vs_q;
      bus.red_o <= r_q;
      bus.green_o <= g_q;
      bus.blue_o <= b_q;
      if (frame_start) begin
        pat <= bus.pattern_sel_i;
        bus.frame_cnt_o <= bus.frame_cnt_o + 8'd1;
        box_x <= nx[9:0];
        box_y <= ny[8:0];
        dir_x <= ndx;
        dir_y <= ndy;
      end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: randomized pixel stream checked through a scoreboard against a frame-level model
module tb_vga_pattern_gen;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  vga_pattern_gen_if bus();
  vga_pattern_gen dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;

  typedef struct {int idx; logic hs; logic vs; logic [11:0] rgb;} exp_t;
  exp_t sb[$];
  int cyc = 0, vectors = 0, miscompares = 0;
  int m_pat, m_fcnt, m_bx, m_by, m_dx, m_dy;
  logic m_prev_vs;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  function automatic logic [11:0] ref_colour(int pat, int h, int v, int fc, int bx, int by, logic de);
    if (!de) return 12'h000;
    case (pat)
      0: return bars[h / 80];
      1: return ((h / 32) % 2 != (v / 32) % 2) ? 12'hFFF : 12'h000;
      2: return {4'((h / 8) % 16), 4'((v / 8) % 16), 4'(fc / 16)};
      default: return (h >= bx && h < bx + 32 && v >= by && v < by + 32) ? 12'hFFF : 12'h00F;
    endcase
  endfunction

  task automatic model_reset();
    m_pat = 0; m_fcnt = 0; m_bx = 0; m_by = 0; m_dx = 0; m_dy = 0; m_prev_vs = 1'b0;
  endtask

  task automatic drive(logic hs, logic vs, logic de, int h, int v, int sel);
    logic [11:0] col;
    @(negedge clk_i);
    bus.hsync_i = hs; bus.vsync_i = vs; bus.display_on_i = de;
    bus.hpos_i = 10'(h); bus.vpos_i = 9'(v); bus.pattern_sel_i = 2'(sel);
    col = ref_colour(m_pat, h, v, m_fcnt, m_bx, m_by, de);
    sb.push_back('{cyc, hs, vs, col});
    if (vs && !m_prev_vs) begin
      m_pat = sel;
      m_fcnt = (m_fcnt + 1) % 256;
      if (m_dx == 0) begin
        if (m_bx + 2 > 608) begin m_bx = 608; m_dx = 1; end else m_bx += 2;
      end else begin
        if (m_bx < 2) begin m_bx = 0; m_dx = 0; end else m_bx -= 2;
      end
      if (m_dy == 0) begin
        if (m_by + 2 > 448) begin m_by = 448; m_dy = 1; end else m_by += 2;
      end else begin
        if (m_by < 2) begin m_by = 0; m_dy = 0; end else m_by -= 2;
      end
    end
    m_prev_vs = vs;
  endtask

  task automatic frame(int sel, int npix, bit mid_change);
    drive(0, 1, 0, 700, 490, sel);
    drive(0, 1, 0, 700, 490, sel);
    drive(0, 0, 0, 700, 490, sel);
    for (int i = 0; i < npix; i++) begin
      int h, v, s;
      logic de;
      de = $urandom_range(0, 7) != 0;
      if (m_pat == 3 && $urandom_range(0, 1) == 1) begin
        h = m_bx - 1 + int'($urandom_range(0, 33));
        v = m_by - 1 + int'($urandom_range(0, 33));
        h = h < 0 ? 0 : h > 639 ? 639 : h;
        v = v < 0 ? 0 : v > 479 ? 479 : v;
      end else begin
        h = $urandom_range(0, 639);
        v = $urandom_range(0, 479);
      end
      s = (mid_change && i > npix / 2) ? int'($urandom_range(0, 3)) : sel;
      drive(1'($urandom_range(0, 1)), 0, de, h, v, s);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    vectors++;
    if ({bus.hsync_o, bus.vsync_o, bus.red_o, bus.green_o, bus.blue_o, bus.frame_cnt_o} !== 22'd0) begin
      miscompares++;
      $display("FAIL async_reset got hs=%b vs=%b rgb=%h%h%h fcnt=%0d want all 0",
               bus.hsync_o, bus.vsync_o, bus.red_o, bus.green_o, bus.blue_o, bus.frame_cnt_o);
    end
    bus.hsync_i = 0; bus.vsync_i = 0; bus.display_on_i = 0;
    bus.hpos_i = 0; bus.vpos_i = 0; bus.pattern_sel_i = 0;
    model_reset();
    sb.delete();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  always @(posedge clk_i) begin
    exp_t e;
    cyc++;
    #1;
    if (rst_i) begin
      while (sb.size() > 0 && sb[0].idx < cyc - 2) void'(sb.pop_front());
      if (sb.size() > 0 && sb[0].idx == cyc - 2) begin
        e = sb.pop_front();
        vectors++;
        if ({bus.hsync_o, bus.vsync_o, bus.red_o, bus.green_o, bus.blue_o} !== {e.hs, e.vs, e.rgb}) begin
          miscompares++;
          $display("FAIL pixel idx=%0d got hs=%b vs=%b rgb=%h%h%h want hs=%b vs=%b rgb=%h",
                   e.idx, bus.hsync_o, bus.vsync_o, bus.red_o, bus.green_o, bus.blue_o, e.hs, e.vs, e.rgb);
        end
      end
      vectors++;
      if (bus.frame_cnt_o !== 8'(m_fcnt)) begin
        miscompares++;
        $display("FAIL frame_cnt cyc=%0d got %0d want %0d", cyc, bus.frame_cnt_o, m_fcnt);
      end
    end
  end

  initial begin
    bus.hsync_i = 0; bus.vsync_i = 0; bus.display_on_i = 0;
    bus.hpos_i = 0; bus.vpos_i = 0; bus.pattern_sel_i = 0;
    model_reset();
    #20 do_reset();
    frame(0, 10, 0);
    drive(1, 0, 1, 100, 10, 0);
    drive(0, 0, 1, 600, 10, 0);
    drive(0, 0, 1, 500, 10, 0);
    frame(1, 10, 0);
    drive(0, 0, 1, 31, 0, 1);
    drive(0, 0, 1, 32, 0, 1);
    drive(0, 0, 0, 32, 0, 1);
    frame(0, 20, 1);
    frame(1, 8, 0);
    for (int f = 0; f < 320; f++) frame(3, 12, 0);
    for (int f = 0; f < 40; f++) frame($urandom_range(0, 3), 20, 1);
    frame(2, 6, 0);
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, 0, 1, $urandom_range(0, 639), $urandom_range(0, 479), 3);
    frame(3, 30, 0);
    frame(2, 20, 0);
    repeat (4) @(posedge clk_i);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
